uart_fifo: RTL and testbench

Parametrised successor to the existing single-byte UART. Full-duplex 8N1-style serial port with configurable bit timing and data width, and independent RX and TX FIFOs. Sits between the FPGA pins (uart_rx/uart_tx) and the CPU bus strobes. The CPU can queue several bytes for transmit and drain several received bytes without losing data.

---
 rtl/uart_fifo.sv | 452 ++++++++++++++++++++++++++++++++++++++++
 tb/tb_uart_fifo.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo.sv
// -----------------------------------------------------------------------------
// uart_fifo
//   Full-duplex serial port (start + DATA_BITS + [parity] + stop, LSB first)
//   with independent RX and TX FIFOs between the pins and the CPU bus strobes.
//
//   Optional build macro: UART_PARITY_EN
//     Inserts a parity bit after the data bits on TX and checks it on RX.
//     Adds parameter PARITY_ODD (0 = even) and the sticky output parity_err.
//
// Ports
//   full_clk        sole clock
//   rst_n           asynchronous active-low reset (release is synchronised)
//   uart_rx         serial input, asynchronous, idle high
//   uart_tx         serial output, registered, idle high
//   send_in         word to transmit
//   set_send        push send_in into the TX FIFO (one push per cycle high)
//   tx_full         TX FIFO full; a push without a same-cycle pop is dropped
//   tx_busy         TX FSM not idle or TX FIFO non-empty
//   recv_out        RX FIFO head (first-word fall-through), 0 when empty
//   get_recv        RX FIFO non-empty
//   set_recv_clear  pop the RX FIFO head (ignored when empty)
//   rx_overrun      sticky: received word dropped because RX FIFO was full
//   frame_err       sticky: stop bit sampled low
//   parity_err      sticky: parity mismatch (UART_PARITY_EN builds only)
//   err_clear       clears the sticky error flags; a same-cycle set wins
// -----------------------------------------------------------------------------
module uart_fifo #(
   parameter int CLKS_PER_BIT = 8,
   parameter int DATA_BITS    = 8,
   parameter int RX_DEPTH     = 4,
   parameter int TX_DEPTH     = 4
`ifdef UART_PARITY_EN
   ,
   parameter int PARITY_ODD   = 0
`endif
) (
   input  logic                 full_clk,
   input  logic                 rst_n,
   input  logic                 uart_rx,
   output logic                 uart_tx,
   input  logic [DATA_BITS-1:0] send_in,
   input  logic                 set_send,
   output logic                 tx_full,
   output logic                 tx_busy,
   output logic [DATA_BITS-1:0] recv_out,
   output logic                 get_recv,
   input  logic                 set_recv_clear,
   output logic                 rx_overrun,
   output logic                 frame_err,
`ifdef UART_PARITY_EN
   output logic                 parity_err,
`endif
   input  logic                 err_clear
);

   localparam int CW  = $clog2(CLKS_PER_BIT);
   localparam int BW  = $clog2(DATA_BITS);
   localparam int RAW = $clog2(RX_DEPTH);
   localparam int TAW = $clog2(TX_DEPTH);

   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

`ifdef UART_PARITY_EN
   // Parity bit that makes the frame match the configured sense.
   function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
      parity_bit = (^d) ^ (PARITY_ODD != 0);
   endfunction
`endif

   // ---------------------------------------------------------------------------
   // Reset: asserts asynchronously, releases on a clock edge
   // ---------------------------------------------------------------------------
   logic rst_meta_n;
   logic rst_sync_n;

   always_ff @(posedge full_clk or negedge rst_n) begin
      if (!rst_n) begin
         rst_meta_n <= 1'b0;
         rst_sync_n <= 1'b0;
      end else begin
         rst_meta_n <= 1'b1;
         rst_sync_n <= rst_meta_n;
      end
   end

   // ---------------------------------------------------------------------------
   // RX input synchroniser and falling-edge detect
   // ---------------------------------------------------------------------------
   logic rx_meta;
   logic rx_sync;
   logic rx_prev;
   logic rx_fall;

   always_ff @(posedge full_clk or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= uart_rx;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
      end
   end

   assign rx_fall = rx_prev & ~rx_sync;

   // ---------------------------------------------------------------------------
   // RX FSM
   // ---------------------------------------------------------------------------
   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_PARITY,
      RX_STOP,
      RX_WAIT
   } rx_state_t;

   rx_state_t            rx_state;
   rx_state_t            rx_state_nxt;
   logic [CW-1:0]        rx_cnt;
   logic [BW-1:0]        rx_bit;
   logic [DATA_BITS-1:0] rx_shift;
   logic                 rx_cnt_clr;
   logic                 rx_shift_en;
   logic                 rx_push;
   logic                 rx_frame_set;
   logic                 rx_par_set;

   always_ff @(posedge full_clk or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
         rx_state <= RX_IDLE;
         rx_cnt   <= '0;
         rx_bit   <= '0;
      end else begin
         rx_state <= rx_state_nxt;
         rx_cnt   <= rx_cnt_clr ? '0 : rx_cnt + 1'b1;
         if (rx_state == RX_START)
            rx_bit <= '0;
         else if (rx_shift_en)
            rx_bit <= rx_bit + 1'b1;
      end
   end

   // Received data is a pure datapath register and needs no reset.
   always_ff @(posedge full_clk) begin
      if (rx_shift_en)
         rx_shift <= {rx_sync, rx_shift[DATA_BITS-1:1]};
   end

   always_comb begin
      rx_state_nxt = rx_state;
      rx_cnt_clr   = 1'b0;
      rx_shift_en  = 1'b0;
      rx_push      = 1'b0;
      rx_frame_set = 1'b0;
      rx_par_set   = 1'b0;
      case (rx_state)
         RX_IDLE: begin
            if (rx_fall) begin
               rx_state_nxt = RX_START;
               rx_cnt_clr   = 1'b1;
            end
         end
         RX_START: begin
            // Re-check the line half a bit in; a short low pulse is a glitch.
            if (rx_cnt == CNT_HALF) begin
               rx_cnt_clr   = 1'b1;
               rx_state_nxt = rx_sync ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (rx_cnt == CNT_LAST) begin
               rx_cnt_clr  = 1'b1;
               rx_shift_en = 1'b1;
               if (rx_bit == BIT_LAST) begin
`ifdef UART_PARITY_EN
                  rx_state_nxt = RX_PARITY;
`else
                  rx_state_nxt = RX_STOP;
`endif
               end
            end
         end
`ifdef UART_PARITY_EN
         RX_PARITY: begin
            if (rx_cnt == CNT_LAST) begin
               rx_cnt_clr   = 1'b1;
               rx_par_set   = (rx_sync != parity_bit(rx_shift));
               rx_state_nxt = RX_STOP;
            end
         end
`endif
         RX_STOP: begin
            // Leave at mid stop bit so the following start edge is not missed.
            if (rx_cnt == CNT_LAST) begin
               rx_cnt_clr = 1'b1;
               if (rx_sync) begin
                  rx_push      = 1'b1;
                  rx_state_nxt = RX_IDLE;
               end else begin
                  rx_frame_set = 1'b1;
                  rx_state_nxt = RX_WAIT;
               end
            end
         end
         RX_WAIT: begin
            // After a framing error, hold off until the line returns high.
            if (rx_sync)
               rx_state_nxt = RX_IDLE;
         end
         default: rx_state_nxt = RX_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // RX FIFO (first-word fall-through)
   // ---------------------------------------------------------------------------
   logic [DATA_BITS-1:0] rx_mem [RX_DEPTH];
   logic [RAW:0]         rx_wr;
   logic [RAW:0]         rx_rd;
   logic                 rx_empty;
   logic                 rx_full;
   logic                 rx_pop;
   logic                 rx_wr_en;
   logic                 rx_ovr_set;

   assign rx_empty   = (rx_wr == rx_rd);
   assign rx_full    = (rx_wr[RAW] != rx_rd[RAW]) && (rx_wr[RAW-1:0] == rx_rd[RAW-1:0]);
   assign rx_pop     = set_recv_clear && !rx_empty;
   // A pop in the same cycle frees the slot being written.
   assign rx_wr_en   = rx_push && (!rx_full || rx_pop);
   assign rx_ovr_set = rx_push && rx_full && !rx_pop;

   always_ff @(posedge full_clk or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
         rx_wr <= '0;
         rx_rd <= '0;
      end else begin
         if (rx_wr_en)
            rx_wr <= rx_wr + 1'b1;
         if (rx_pop)
            rx_rd <= rx_rd + 1'b1;
      end
   end

   always_ff @(posedge full_clk) begin
      if (rx_wr_en)
         rx_mem[rx_wr[RAW-1:0]] <= rx_shift;
   end

   assign get_recv = !rx_empty;
   assign recv_out = rx_empty ? '0 : rx_mem[rx_rd[RAW-1:0]];

   // ---------------------------------------------------------------------------
   // Sticky error flags
   // ---------------------------------------------------------------------------
   always_ff @(posedge full_clk or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
         rx_overrun <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         if (rx_ovr_set)
            rx_overrun <= 1'b1;
         else if (err_clear)
            rx_overrun <= 1'b0;
         if (rx_frame_set)
            frame_err <= 1'b1;
         else if (err_clear)
            frame_err <= 1'b0;
      end
   end

`ifdef UART_PARITY_EN
   always_ff @(posedge full_clk or negedge rst_sync_n) begin
      if (!rst_sync_n)
         parity_err <= 1'b0;
      else if (rx_par_set)
         parity_err <= 1'b1;
      else if (err_clear)
         parity_err <= 1'b0;
   end
`endif

   // ---------------------------------------------------------------------------
   // TX FIFO
   // ---------------------------------------------------------------------------
   logic [DATA_BITS-1:0] tx_mem [TX_DEPTH];
   logic [TAW:0]         tx_wr;
   logic [TAW:0]         tx_rd;
   logic                 tx_empty;
   logic                 tx_pop;
   logic                 tx_wr_en;
   logic [DATA_BITS-1:0] tx_head;

   assign tx_empty = (tx_wr == tx_rd);
   assign tx_full  = (tx_wr[TAW] != tx_rd[TAW]) && (tx_wr[TAW-1:0] == tx_rd[TAW-1:0]);
   assign tx_wr_en = set_send && (!tx_full || tx_pop);
   assign tx_head  = tx_mem[tx_rd[TAW-1:0]];

   always_ff @(posedge full_clk or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
         tx_wr <= '0;
         tx_rd <= '0;
      end else begin
         if (tx_wr_en)
            tx_wr <= tx_wr + 1'b1;
         if (tx_pop)
            tx_rd <= tx_rd + 1'b1;
      end
   end

   always_ff @(posedge full_clk) begin
      if (tx_wr_en)
         tx_mem[tx_wr[TAW-1:0]] <= send_in;
   end

   // ---------------------------------------------------------------------------
   // TX FSM
   // ---------------------------------------------------------------------------
   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_PARITY,
      TX_STOP
   } tx_state_t;

   tx_state_t            tx_state;
   tx_state_t            tx_state_nxt;
   logic [CW-1:0]        tx_cnt;
   logic [BW-1:0]        tx_bit;
   logic [DATA_BITS-1:0] tx_shift;
   logic                 tx_cnt_clr;
   logic                 tx_load;
   logic                 tx_shift_en;
   logic                 tx_line_nxt;
`ifdef UART_PARITY_EN
   logic                 tx_par;
`endif

   always_ff @(posedge full_clk or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
         tx_state <= TX_IDLE;
         tx_cnt   <= '0;
         tx_bit   <= '0;
         uart_tx  <= 1'b1;
      end else begin
         tx_state <= tx_state_nxt;
         tx_cnt   <= tx_cnt_clr ? '0 : tx_cnt + 1'b1;
         if (tx_load)
            tx_bit <= '0;
         else if (tx_shift_en)
            tx_bit <= tx_bit + 1'b1;
         uart_tx  <= tx_line_nxt;
      end
   end

   always_ff @(posedge full_clk) begin
      if (tx_load)
         tx_shift <= tx_head;
      else if (tx_shift_en)
         tx_shift <= tx_shift >> 1;
   end

`ifdef UART_PARITY_EN
   always_ff @(posedge full_clk) begin
      if (tx_load)
         tx_par <= parity_bit(tx_head);
   end
`endif

   // uart_tx is the registered copy of tx_line_nxt, so the pin never glitches.
   always_comb begin
      tx_state_nxt = tx_state;
      tx_cnt_clr   = 1'b0;
      tx_pop       = 1'b0;
      tx_load      = 1'b0;
      tx_shift_en  = 1'b0;
      tx_line_nxt  = uart_tx;
      case (tx_state)
         TX_IDLE: begin
            tx_line_nxt = 1'b1;
            if (!tx_empty) begin
               tx_state_nxt = TX_START;
               tx_pop       = 1'b1;
               tx_load      = 1'b1;
               tx_cnt_clr   = 1'b1;
               tx_line_nxt  = 1'b0;
            end
         end
         TX_START: begin
            if (tx_cnt == CNT_LAST) begin
               tx_state_nxt = TX_DATA;
               tx_cnt_clr   = 1'b1;
               tx_line_nxt  = tx_shift[0];
            end
         end
         TX_DATA: begin
            if (tx_cnt == CNT_LAST) begin
               tx_cnt_clr = 1'b1;
               if (tx_bit == BIT_LAST) begin
`ifdef UART_PARITY_EN
                  tx_state_nxt = TX_PARITY;
                  tx_line_nxt  = tx_par;
`else
                  tx_state_nxt = TX_STOP;
                  tx_line_nxt  = 1'b1;
`endif
               end else begin
                  tx_shift_en = 1'b1;
                  tx_line_nxt = tx_shift[1];
               end
            end
         end
`ifdef UART_PARITY_EN
         TX_PARITY: begin
            if (tx_cnt == CNT_LAST) begin
               tx_state_nxt = TX_STOP;
               tx_cnt_clr   = 1'b1;
               tx_line_nxt  = 1'b1;
            end
         end
`endif
         TX_STOP: begin
            // Chain straight into the next start bit when more data is queued.
            if (tx_cnt == CNT_LAST) begin
               tx_cnt_clr = 1'b1;
               if (!tx_empty) begin
                  tx_state_nxt = TX_START;
                  tx_pop       = 1'b1;
                  tx_load      = 1'b1;
                  tx_line_nxt  = 1'b0;
               end else begin
                  tx_state_nxt = TX_IDLE;
                  tx_line_nxt  = 1'b1;
               end
            end
         end
         default: begin
            tx_state_nxt = TX_IDLE;
            tx_line_nxt  = 1'b1;
         end
      endcase
   end

   assign tx_busy = (tx_state != TX_IDLE) || !tx_empty;

endmodule

// File: tb/tb_uart_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_fifo
//   Directed bench for uart_fifo with default parameters (8 clocks per bit,
//   8 data bits, 4-deep FIFOs). Inputs are driven 1 time unit after the rising
//   edge and outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_uart_fifo;

   logic       full_clk;
   logic       rst_n;
   logic       uart_rx;
   logic       uart_tx;
   logic [7:0] send_in;
   logic       set_send;
   logic       tx_full;
   logic       tx_busy;
   logic [7:0] recv_out;
   logic       get_recv;
   logic       set_recv_clear;
   logic       rx_overrun;
   logic       frame_err;
   logic       err_clear;
`ifdef UART_PARITY_EN
   logic       parity_err;
`endif

   int errors = 0;
   int checks = 0;

   uart_fifo dut (
      .full_clk       (full_clk),
      .rst_n          (rst_n),
      .uart_rx        (uart_rx),
      .uart_tx        (uart_tx),
      .send_in        (send_in),
      .set_send       (set_send),
      .tx_full        (tx_full),
      .tx_busy        (tx_busy),
      .recv_out       (recv_out),
      .get_recv       (get_recv),
      .set_recv_clear (set_recv_clear),
      .rx_overrun     (rx_overrun),
      .frame_err      (frame_err),
`ifdef UART_PARITY_EN
      .parity_err     (parity_err),
`endif
      .err_clear      (err_clear)
   );

   initial full_clk = 1'b0;
   always #5 full_clk = ~full_clk;

   initial begin
      #500000;
      $display("FAIL watchdog: observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge full_clk);
      #1;
   endtask

   // Drive one serial frame: start 0, d LSB first, then the given stop level.
   task automatic rx_frame(input logic [7:0] d, input logic stop);
      logic [9:0] f;
      f = {stop, d, 1'b0};
      for (int i = 0; i < 10; i++) begin
         uart_rx = f[i];
         step(8);
      end
      uart_rx = 1'b1;
   endtask

   task automatic pop_rx;
      set_recv_clear = 1'b1;
      step(1);
      set_recv_clear = 1'b0;
   endtask

   // Entered at the middle of a start bit; returns at the middle of the next
   // bit period after the stop bit. end_val is uart_tx just after the edge
   // that ends the stop bit (0 when the next frame follows with no gap).
   task automatic tx_frame(input string tag, input logic [7:0] d, output logic end_val);
      logic [9:0] got;
      got[0] = uart_tx;
      for (int i = 1; i < 10; i++) begin
         step(8);
         got[i] = uart_tx;
      end
      step(4);
      end_val = uart_tx;
      step(4);
      check(tag, {6'd0, got}, {6'd0, 1'b1, d, 1'b0});
   endtask

   initial begin
      logic ev;
      logic [7:0] exp_q [4];

      rst_n          = 1'b1;
      uart_rx        = 1'b1;
      send_in        = 8'h00;
      set_send       = 1'b0;
      set_recv_clear = 1'b0;
      err_clear      = 1'b0;
      #2 rst_n = 1'b0;
      step(3);

      // Reset state
      check("rst_uart_tx",    uart_tx,    1'b1);
      check("rst_tx_full",    tx_full,    1'b0);
      check("rst_tx_busy",    tx_busy,    1'b0);
      check("rst_get_recv",   get_recv,   1'b0);
      check("rst_recv_out",   recv_out,   8'h00);
      check("rst_rx_overrun", rx_overrun, 1'b0);
      check("rst_frame_err",  frame_err,  1'b0);
      rst_n = 1'b1;
      step(5);

      // RX single frame 0x41, then pop
      rx_frame(8'h41, 1'b1);
      step(2);
      check("rx41_get",  get_recv, 1'b1);
      check("rx41_data", recv_out, 8'h41);
      pop_rx();
      check("rx41_pop_get",  get_recv, 1'b0);
      check("rx41_pop_data", recv_out, 8'h00);
      pop_rx();
      check("rx_pop_empty_get", get_recv, 1'b0);

      // TX single frame 0x41 from idle
      send_in  = 8'h41;
      set_send = 1'b1;
      step(1);
      set_send = 1'b0;
      check("tx41_idle_line", uart_tx, 1'b1);
      check("tx41_busy",      tx_busy, 1'b1);
      step(1);
      check("tx41_start_lat", uart_tx, 1'b0);
      step(3);
      tx_frame("tx41_frame", 8'h41, ev);
      check("tx41_end_line", ev, 1'b1);
      check("tx41_busy_done", tx_busy, 1'b0);

      // TX back-to-back: 55 AA 0F F0 33 fill the FIFO, 99 is dropped
      step(4);
      send_in  = 8'h55;
      set_send = 1'b1;
      step(1);
      send_in = 8'hAA;
      step(1);
      check("b2b_start_lat", uart_tx, 1'b0);
      send_in = 8'h0F;
      step(1);
      send_in = 8'hF0;
      step(1);
      send_in = 8'h33;
      step(1);
      check("b2b_tx_full", tx_full, 1'b1);
      send_in = 8'h99;
      step(1);
      set_send = 1'b0;
      check("b2b_tx_full_hold", tx_full, 1'b1);
      tx_frame("b2b_55", 8'h55, ev);
      check("b2b_gap1", ev, 1'b0);
      tx_frame("b2b_AA", 8'hAA, ev);
      check("b2b_gap2", ev, 1'b0);
      tx_frame("b2b_0F", 8'h0F, ev);
      check("b2b_gap3", ev, 1'b0);
      tx_frame("b2b_F0", 8'hF0, ev);
      check("b2b_gap4", ev, 1'b0);
      tx_frame("b2b_33", 8'h33, ev);
      check("b2b_end_line", ev, 1'b1);
      check("b2b_busy_done", tx_busy, 1'b0);
      check("b2b_full_done", tx_full, 1'b0);
      step(20);
      check("b2b_no_extra", uart_tx, 1'b1);

      // RX overrun: five frames, four retained
      exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
      for (int i = 0; i < 4; i++) rx_frame(exp_q[i], 1'b1);
      step(2);
      check("ovr_before", rx_overrun, 1'b0);
      rx_frame(8'h55, 1'b1);
      step(2);
      check("ovr_set", rx_overrun, 1'b1);
      for (int i = 0; i < 4; i++) begin
         check("ovr_order", recv_out, exp_q[i]);
         pop_rx();
      end
      check("ovr_drained", get_recv, 1'b0);
      check("ovr_sticky", rx_overrun, 1'b1);
      err_clear = 1'b1;
      step(1);
      err_clear = 1'b0;
      check("ovr_cleared", rx_overrun, 1'b0);

      // RX glitch rejection and framing error
      uart_rx = 1'b0;
      step(2);
      uart_rx = 1'b1;
      step(20);
      check("glitch_no_byte", get_recv, 1'b0);
      rx_frame(8'h5A, 1'b0);
      step(10);
      check("ferr_set", frame_err, 1'b1);
      check("ferr_no_byte", get_recv, 1'b0);
      err_clear = 1'b1;
      step(1);
      err_clear = 1'b0;
      check("ferr_cleared", frame_err, 1'b0);
      rx_frame(8'h3C, 1'b1);
      step(2);
      check("recover_data", recv_out, 8'h3C);

      // Reset in the middle of a TX data bit, with RX and TX FIFOs occupied
      send_in  = 8'h00;
      set_send = 1'b1;
      step(1);
      send_in = 8'h7E;
      step(1);
      set_send = 1'b0;
      step(20);
      check("mid_tx_low", uart_tx, 1'b0);
      rst_n = 1'b0;
      #1;
      check("mid_rst_line",  uart_tx,  1'b1);
      check("mid_rst_busy",  tx_busy,  1'b0);
      check("mid_rst_recv",  get_recv, 1'b0);
      check("mid_rst_rdata", recv_out, 8'h00);
      check("mid_rst_full",  tx_full,  1'b0);
      step(3);
      rst_n = 1'b1;
      step(5);
      check("post_rst_busy", tx_busy,  1'b0);
      check("post_rst_recv", get_recv, 1'b0);
      step(30);
      check("post_rst_line", uart_tx,  1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
